// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NOP   = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110,
    MD_RSVD  = 3'b111
  } mdop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

  localparam logic [31:0] MDU_DIVZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit,
// subtract the divisor if it fits.
module mdu_div_step #(
  parameter int n = 32
) (
  input  logic [n-1:0] rem,
  input  logic         dbit,
  input  logic [n-1:0] dvs,
  output logic [n-1:0] rem_nxt,
  output logic         qbit
);

  logic [n:0] sh;
  logic [n:0] diff;

  // Remainder stays below the divisor, so the n-bit result never overflows.
  assign sh      = {rem, dbit};
  assign diff    = sh - {1'b0, dvs};
  assign qbit    = ~diff[n];
  assign rem_nxt = qbit ? diff[n-1:0] : sh[n-1:0];

endmodule

// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO
// registers for the execute stage.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   mdop,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  mdu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*n-1:0] p_q, p_d;
  logic [n-1:0]  mc_q, mc_d;
  logic [n-1:0]  hi_q, hi_d;
  logic [n-1:0]  lo_q, lo_d;
  logic          neg_q, neg_d;
  logic          rneg_q, rneg_d;
  logic          dz_q, dz_d;
  logic          isdiv_q, isdiv_d;
  logic          done_q, done_d;

  mdop_t         op;
  logic          sgn;
  logic          a_neg, b_neg;
  logic [n-1:0]  a_mag, b_mag;
  logic [n:0]    sum;
  logic [n-1:0]  rem_nxt;
  logic          qbit;
  logic [2*n-1:0] prod;
  logic [n-1:0]  quo, rem;

  assign op    = mdop_t'(mdop);
  assign sgn   = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg = sgn & a[n-1];
  assign b_neg = sgn & b[n-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign sum = {1'b0, p_q[2*n-1:n]} +
               (p_q[0] ? {1'b0, mc_q} : '0);

  mdu_div_step #(.n(n)) u_step (
    .rem     (p_q[2*n-1:n]),
    .dbit    (p_q[n-1]),
    .dvs     (mc_q),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  assign prod = neg_q ? -p_q : p_q;
  assign quo  = neg_q ? -p_q[n-1:0] : p_q[n-1:0];
  assign rem  = rneg_q ? -p_q[2*n-1:n] : p_q[2*n-1:n];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    mc_d    = mc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    isdiv_d = isdiv_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            MD_MULT, MD_MULTU: begin
              state_d = MUL;
              cnt_d   = '0;
              p_d     = {{n{1'b0}}, b_mag};
              mc_d    = a_mag;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = 1'b0;
              dz_d    = 1'b0;
              isdiv_d = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              state_d = DIV;
              cnt_d   = '0;
              p_d     = {{n{1'b0}}, a_mag};
              mc_d    = b_mag;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              dz_d    = (b == '0);
              isdiv_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        p_d   = {sum, p_q[n-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      DIV: begin
        p_d   = {rem_nxt, p_q[n-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (isdiv_q) begin
          // Remainder of x/0 is x itself; quotient is forced.
          hi_d = rem;
          lo_d = dz_q ? n'(MDU_DIVZERO_LO) : quo;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      mc_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      isdiv_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      mc_q    <= mc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      isdiv_q <= isdiv_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed vector bench for hilo_mdu: op table plus
// abort and ignored-start sequences.
module tb_hilo_mdu;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total;
  int passed;

  hilo_mdu #(.n(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .mdop  (mdop),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    bit multi;
    multi = (v.op >= 3'd1) && (v.op <= 3'd4);
    @(negedge clock);
    start = 1'b1; mdop = v.op; a = v.a; b = v.b;
    @(posedge clock); #1;
    start = 1'b0;
    if (multi) begin
      chk($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
      wait_done(0, cyc);
      chk($sformatf("v%0d latency", idx), cyc, 32'd33);
    end else begin
      chk($sformatf("v%0d busy", idx), 32'(busy), 32'd0);
      chk($sformatf("v%0d done", idx), 32'(done), 32'd0);
    end
    chk($sformatf("v%0d hi", idx), hi, v.hi);
    chk($sformatf("v%0d lo", idx), lo, v.lo);
    if (multi) begin
      chk($sformatf("v%0d busy_end", idx), 32'(busy), 32'd0);
      @(posedge clock); #1;
      chk($sformatf("v%0d done_pulse", idx), 32'(done), 32'd0);
    end
  endtask

  vec_t vecs[13];

  initial begin
    int cyc;
    int dones;
    total = 0; passed = 0;
    reset = 1'b1; start = 1'b0; mdop = 3'd0; a = '0; b = '0;

    vecs[0]  = '{3'd5, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0};
    vecs[1]  = '{3'd6, 32'hCAFE_BABE, 32'h0,         32'h1234_5678, 32'hCAFE_BABE};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5]  = '{3'd4, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF};
    vecs[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[7]  = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[8]  = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[10] = '{3'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[11] = '{3'd0, 32'h5555_5555, 32'h1,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[12] = '{3'd2, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780};

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // MTLO arriving while a multiply is in flight must be dropped.
    @(negedge clock);
    start = 1'b1; mdop = 3'd1; a = 32'd6; b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clock); #1;
    end
    start = 1'b1; mdop = 3'd6; a = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    start = 1'b0; mdop = 3'd0;
    chk("ign lo_mid", lo, 32'h2345_6780);
    chk("ign busy_mid", 32'(busy), 32'd1);
    wait_done(10, cyc);
    chk("ign latency", cyc, 32'd33);
    chk("ign hi", hi, 32'h0);
    chk("ign lo", lo, 32'd42);

    // Reset during a multiply discards it with no done.
    @(negedge clock);
    start = 1'b1; mdop = 3'd2; a = 32'd5; b = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    chk("abort busy", 32'(busy), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    chk("abort done", dones, 32'd0);
    chk("abort lo_end", lo, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
